// File: rtl/i2s_sample_fifo.sv
// rtl/i2s_sample_fifo.sv - I2S channel select, 24->16 bit scaling and DMA sample FIFO
module i2s_sample_fifo #(
  parameter int DEPTH   = 16,
  parameter int THRESH  = 8,
  parameter int CHANNEL = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       flush,
  input  logic [3:0]                 shift,
  input  logic [31:0]                sample_in,
  input  logic                       sample_stb,
  input  logic                       sample_ws,
  output logic [15:0]                rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       dma_req,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] THRESH_L = LW'(THRESH);
  localparam logic CH = 1'(CHANNEL);

  // The receiver word carries 8 pad bits below the 24-bit sample.
  logic unused_pad;
  assign unused_pad = ^sample_in[7:0];

  logic [15:0]        mem [DEPTH];
  logic [LW-1:0]      wptr;
  logic [LW-1:0]      rptr;
  logic [LW-1:0]      level_q;
  logic               stage_valid;
  logic [15:0]        stage_data;

  logic               capture;
  logic signed [23:0] s24;
  logic signed [23:0] shifted;
  logic [15:0]        scaled;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               ovf_set;

  assign capture = sample_stb && en && (sample_ws == CH) && !flush;
  assign s24     = sample_in[31:8];
  assign shifted = s24 >>> shift;

  // Saturate to 16 bits: upper nine bits must all equal the sign for an exact fit.
  always_comb begin
    scaled = shifted[15:0];
    if (shifted[23:15] != {9{shifted[23]}}) begin
      scaled = shifted[23] ? 16'h8000 : 16'h7FFF;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // Flush overrides everything in its cycle: no pop, no push, no overflow.
  assign pop     = !empty && rd_ready && !flush;
  assign push    = stage_valid && !flush && (!full || pop);
  assign ovf_set = stage_valid && !flush && full && !pop;

  // Pipeline stage holding one scaled sample on its way into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_data  <= 16'h0000;
    end else begin
      stage_valid <= capture;
      if (capture) begin
        stage_data <= scaled;
      end
    end
  end

  // Sample storage; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= stage_data;
    end
  end

  // Pointers and registered occupancy move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + LW'(1);
      end
      if (pop) begin
        rptr <= rptr + LW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? 16'h0000 : mem[rptr[AW-1:0]];
  assign level    = level_q;
  assign dma_req  = (level_q >= THRESH_L);

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// tb/tb_i2s_sample_fifo.sv - directed vector bench for i2s_sample_fifo
module tb_i2s_sample_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic [3:0]  shift;
  logic [31:0] sample_in;
  logic        sample_stb;
  logic        sample_ws;
  logic        rd_ready;
  logic        ovf_clr;

  logic [15:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic [4:0]  level0, level1;
  logic        dma_req0, dma_req1;
  logic        ovf0, ovf1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        en;
    logic        ws;
    logic [3:0]  sh;
    logic [31:0] din;
    logic        vld;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  i2s_sample_fifo #(.DEPTH(16), .THRESH(8), .CHANNEL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .shift(shift),
    .sample_in(sample_in), .sample_stb(sample_stb), .sample_ws(sample_ws),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready),
    .level(level0), .dma_req(dma_req0), .ovf(ovf0), .ovf_clr(ovf_clr)
  );

  i2s_sample_fifo #(.DEPTH(16), .THRESH(8), .CHANNEL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .shift(shift),
    .sample_in(sample_in), .sample_stb(sample_stb), .sample_ws(sample_ws),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready),
    .level(level1), .dma_req(dma_req1), .ovf(ovf1), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock; single-cycle controls drop back to idle afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
    sample_stb = 1'b0;
    rd_ready   = 1'b0;
    flush      = 1'b0;
    ovf_clr    = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] d, input logic ws, input logic [3:0] sh);
    sample_in  = d;
    sample_ws  = ws;
    shift      = sh;
    sample_stb = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'd8,  32'h00123400, 1'b1, 16'h0012};
    vecs[1]  = '{1'b1, 1'b0, 4'd4,  32'h7FFFFF00, 1'b1, 16'h7FFF};
    vecs[2]  = '{1'b1, 1'b0, 4'd4,  32'h80000000, 1'b1, 16'h8000};
    vecs[3]  = '{1'b1, 1'b0, 4'd0,  32'h00001000, 1'b1, 16'h0010};
    vecs[4]  = '{1'b1, 1'b0, 4'd0,  32'h000010FF, 1'b1, 16'h0010};
    vecs[5]  = '{1'b1, 1'b0, 4'd0,  32'h00800000, 1'b1, 16'h7FFF};
    vecs[6]  = '{1'b1, 1'b0, 4'd0,  32'hFF7FFF00, 1'b1, 16'h8000};
    vecs[7]  = '{1'b1, 1'b0, 4'd0,  32'hFF800000, 1'b1, 16'h8000};
    vecs[8]  = '{1'b1, 1'b0, 4'd0,  32'hFFFF0000, 1'b1, 16'hFF00};
    vecs[9]  = '{1'b1, 1'b0, 4'd15, 32'h12345600, 1'b1, 16'h0024};
    vecs[10] = '{1'b1, 1'b0, 4'd15, 32'h80000000, 1'b1, 16'hFF00};
    vecs[11] = '{1'b1, 1'b0, 4'd15, 32'hFFFFFF00, 1'b1, 16'hFFFF};
    vecs[12] = '{1'b0, 1'b0, 4'd0,  32'h00001000, 1'b0, 16'h0000};
    vecs[13] = '{1'b1, 1'b1, 4'd0,  32'h00001000, 1'b0, 16'h0000};

    rst_n = 1'b0; en = 1'b1; flush = 1'b0; shift = 4'd0; sample_in = '0;
    sample_stb = 1'b0; sample_ws = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    tick();
    chk("reset rd_valid", 32'(rd_valid0), 0);
    chk("reset rd_data", 32'(rd_data0), 0);
    chk("reset level", 32'(level0), 0);
    chk("reset dma_req", 32'(dma_req0), 0);
    chk("reset ovf", 32'(ovf0), 0);
    rst_n = 1'b1;
    tick();

    // Table: one sample at a time through the scaler and latency path.
    for (int i = 0; i < 14; i++) begin
      en = vecs[i].en;
      strobe(vecs[i].din, vecs[i].ws, vecs[i].sh);
      tick();
      chk($sformatf("v%0d lat1 rd_valid", i), 32'(rd_valid0), 0);
      tick();
      chk($sformatf("v%0d rd_valid", i), 32'(rd_valid0), 32'(vecs[i].vld));
      chk($sformatf("v%0d rd_data", i), 32'(rd_data0), 32'(vecs[i].dout));
      chk($sformatf("v%0d level", i), 32'(level0), 32'(vecs[i].vld));
      if (vecs[i].vld) begin
        rd_ready = 1'b1;
        tick();
        chk($sformatf("v%0d popped", i), 32'(rd_valid0), 0);
      end
    end
    en = 1'b1;
    flush = 1'b1;
    tick();

    // Back-to-back strobes, ordered drain.
    strobe(32'h00123400, 1'b0, 4'd8); tick();
    chk("seq1 e1 rd_valid", 32'(rd_valid0), 0);
    strobe(32'hFFFFFF00, 1'b0, 4'd8); tick();
    chk("seq1 e2 rd_valid", 32'(rd_valid0), 1);
    chk("seq1 e2 rd_data", 32'(rd_data0), 32'h0012);
    strobe(32'h80000000, 1'b0, 4'd8); tick();
    tick();
    chk("seq1 level", 32'(level0), 3);
    chk("seq1 d0", 32'(rd_data0), 32'h0012);
    rd_ready = 1'b1; tick();
    chk("seq1 d1", 32'(rd_data0), 32'hFFFF);
    rd_ready = 1'b1; tick();
    chk("seq1 d2", 32'(rd_data0), 32'h8000);
    rd_ready = 1'b1; tick();
    chk("seq1 empty", 32'(rd_valid0), 0);

    // Channel filtering with alternating WS.
    flush = 1'b1; tick();
    for (int i = 0; i < 12; i++) begin
      strobe(32'(i) << 8, 1'(i % 2), 4'd0);
      tick();
    end
    tick(); tick();
    chk("ch1 level", 32'(level1), 6);
    chk("ch0 level", 32'(level0), 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ch1 d%0d", k), 32'(rd_data1), 32'(2 * k + 1));
      chk($sformatf("ch0 d%0d", k), 32'(rd_data0), 32'(2 * k));
      rd_ready = 1'b1;
      tick();
    end
    chk("ch1 empty", 32'(rd_valid1), 0);

    // Fill to full, threshold, overflow.
    flush = 1'b1; tick();
    for (int j = 1; j <= 17; j++) begin
      strobe(32'(j) << 8, 1'b0, 4'd0);
      tick();
      chk($sformatf("fill%0d level", j), 32'(level0), 32'(j - 1));
      chk($sformatf("fill%0d dma_req", j), 32'(dma_req0), 32'((j - 1) >= 8));
      chk($sformatf("fill%0d ovf", j), 32'(ovf0), 0);
    end
    tick();
    chk("full level", 32'(level0), 16);
    chk("full ovf", 32'(ovf0), 1);
    chk("full head", 32'(rd_data0), 1);
    ovf_clr = 1'b1; tick();
    chk("ovf_clr", 32'(ovf0), 0);
    chk("ovf_clr level", 32'(level0), 16);

    // Push and pop together while full.
    strobe(32'h00006400, 1'b0, 4'd0); tick();
    rd_ready = 1'b1; tick();
    chk("fullpp ovf", 32'(ovf0), 0);
    chk("fullpp level", 32'(level0), 16);
    chk("fullpp head", 32'(rd_data0), 2);

    // Clear coinciding with a new overflow: set wins.
    strobe(32'h00006500, 1'b0, 4'd0); tick();
    ovf_clr = 1'b1; tick();
    chk("clr vs set ovf", 32'(ovf0), 1);
    chk("clr vs set level", 32'(level0), 16);

    // Flush keeps ovf, clears occupancy.
    flush = 1'b1; tick();
    chk("flush level", 32'(level0), 0);
    chk("flush rd_valid", 32'(rd_valid0), 0);
    chk("flush ovf sticky", 32'(ovf0), 1);
    for (int k = 1; k <= 5; k++) begin
      strobe(32'(k) << 8, 1'b0, 4'd0);
      tick();
    end
    tick(); tick();
    chk("five level", 32'(level0), 5);
    strobe(32'h00007700, 1'b0, 4'd0); tick();
    rd_ready = 1'b1; tick();
    chk("pp level", 32'(level0), 5);
    chk("pp head", 32'(rd_data0), 2);
    strobe(32'h00008800, 1'b0, 4'd0); tick();
    strobe(32'h00009900, 1'b0, 4'd0); flush = 1'b1; rd_ready = 1'b1; tick();
    chk("flush2 level", 32'(level0), 0);
    chk("flush2 rd_valid", 32'(rd_valid0), 0);
    chk("flush2 rd_data", 32'(rd_data0), 0);
    tick(); tick();
    chk("flush2 no stale level", 32'(level0), 0);
    chk("flush2 no stale rd_valid", 32'(rd_valid0), 0);

    // Asynchronous reset mid-stream.
    for (int k = 1; k <= 3; k++) begin
      strobe(32'(k) << 8, 1'b0, 4'd0);
      tick();
    end
    tick();
    chk("pre-reset level", 32'(level0), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst rd_valid", 32'(rd_valid0), 0);
    chk("async rst rd_data", 32'(rd_data0), 0);
    chk("async rst level", 32'(level0), 0);
    chk("async rst dma_req", 32'(dma_req0), 0);
    chk("async rst ovf", 32'(ovf0), 0);
    #1;
    rst_n = 1'b1;
    tick(); tick();
    chk("post rst level", 32'(level0), 0);
    chk("post rst rd_valid", 32'(rd_valid0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
